// File: rtl/fetch_pkg.sv
// Shared types and encodings for the instruction fetch/sequencing stage.
// Branch-related constants are only consumed when FETCH_BRANCH_EN is defined.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ISSUE,
        ST_EXEC
    } state_t;

    localparam logic [1:0]  FMT_BRANCH = 2'b10;

    // Condition codes share the encoding of the ALU compare flag.
    localparam logic [1:0]  COND_EQ    = 2'b00;
    localparam logic [1:0]  COND_GT    = 2'b01;
    localparam logic [1:0]  COND_LT    = 2'b10;
    localparam logic [1:0]  COND_NEVER = 2'b11;

    localparam logic [15:0] NOP_INST   = 16'h0002;

endpackage

// File: rtl/fetch_unit_branch_eval.sv
// Next-PC selection, combinational: sequential pc+1, or the embedded target
// for a taken format-10 branch when FETCH_BRANCH_EN is defined.
module branch_eval
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [15:0]       d_inst,
    input  logic [1:0]        cmp_flag,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc + ADDR_W'(1);

`ifdef FETCH_BRANCH_EN
    logic taken;
    logic unused_bits;

    always_comb begin
        taken = 1'b0;
        if (d_inst[1:0] == FMT_BRANCH) begin
            case (d_inst[3:2])
                COND_EQ:    taken = (cmp_flag == COND_EQ);
                COND_GT:    taken = (cmp_flag == COND_GT);
                COND_LT:    taken = (cmp_flag == COND_LT);
                COND_NEVER: taken = 1'b0;
                default:    taken = 1'b0;
            endcase
        end
    end

    // Target bits above ADDR_W+3 are ignored for narrow PCs.
    assign unused_bits = ^d_inst;
    assign next_pc     = taken ? d_inst[ADDR_W+3:4] : pc_inc;
`else
    logic unused_bits;

    assign unused_bits = ^{d_inst, cmp_flag};
    assign next_pc     = pc_inc;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Fetch/sequencing stage: REQ, WAIT, ISSUE, EXEC per instruction; first run 3 cycles after start.
// Stalls in EXEC until done; stop is honoured only at instruction boundaries (FETCH_BRANCH_EN adds branches).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       d_inst,
    output logic              run,
    input  logic              done,
    input  logic [1:0]        cmp_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    state_t            state;
    logic              stop_pend;
    logic [ADDR_W-1:0] next_pc;

    branch_eval #(.ADDR_W(ADDR_W)) u_branch_eval (
        .d_inst   (d_inst),
        .cmp_flag (cmp_flag),
        .pc       (pc),
        .next_pc  (next_pc)
    );

    // pc only moves on the done edge, which is always followed by REQ or IDLE.
    assign mem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= '0;
            d_inst    <= NOP_INST;
            run       <= 1'b0;
            mem_rd    <= 1'b0;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            run    <= 1'b0;
            mem_rd <= 1'b0;
            if (stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_REQ;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    d_inst <= mem_rdata;
                    run    <= 1'b1;
                    state  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (done) begin
                        pc <= next_pc;
                        // A stop arriving on the done cycle itself still counts.
                        if (stop_pend || stop) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state  <= ST_REQ;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage directly upstream of the `cpu` control FSM. It holds the program counter, reads 16-bit instructions from a synchronous-read instruction memory, and presents each instruction on `d_inst` with a one-cycle `run` pulse. It then waits for the FSM's `done`, advances or branches the PC, and fetches the next instruction until stopped.

## Interface
- `ADDR_W`, 8, PC and instruction-memory address width; legal range 4..12.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin execution from the current PC; honoured only in IDLE.
- `stop`  in  1  halt request, sticky until honoured at the next instruction boundary.
- `mem_addr`  out  ADDR_W  instruction memory address.
- `mem_rd`  out  1  memory read strobe.
- `mem_rdata`  in  16  read data, valid exactly one cycle after `mem_rd`.
- `d_inst`  out  16  registered instruction to the `cpu` FSM; stable from ISSUE through the `done` cycle.
- `run`  out  1  one-cycle pulse that starts the FSM.
- `done`  in  1  FSM completion, one cycle wide.
- `cmp_flag`  in  2  ALU compare result: 00 eq, 01 gt, 10 lt.
- `pc`  out  ADDR_W  current program counter.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, ISSUE, EXEC.
- IDLE: `start`=1 moves to REQ.
- REQ: `mem_rd`=1 and `mem_addr`=`pc`. Moves to WAIT.
- WAIT: `d_inst` <= `mem_rdata`. Moves to ISSUE.
- ISSUE: `run`=1 for exactly this cycle. Moves to EXEC.
- EXEC: waits for `done`. On `done`, update the PC (rules below). Then go to IDLE if a stop is pending, otherwise to REQ.
- PC update: `pc` <= `pc`+1 modulo 2^ADDR_W, so `pc` at all-ones wraps to 0.
- The branch exception to the PC update is defined under Configuration.
- `stop` is latched into `stop_pend` in any state. It is cleared when IDLE is entered. It never aborts an instruction that is in flight.
- `start` outside IDLE is ignored. If `start` and `stop` arrive together in IDLE, `start` wins, one instruction executes, then the unit returns to IDLE.
- `done` outside EXEC is ignored.
- Reset values:
  - state IDLE, `pc`=0
  - `d_inst`=16'h0002 (format 10, no-op for the FSM)
  - `run`=0, `mem_rd`=0, `mem_addr`=0
  - `busy`=0, `stop_pend`=0
- Reset mid-operation returns to these values on the next edge, discarding the in-flight instruction.

## Timing
- Start to first `run`: `start` is sampled in IDLE at edge 0. REQ is cycle 1, WAIT is cycle 2, and `run` goes high in cycle 3.
- Steady state, with the FSM taking S0/S1/S2: REQ, WAIT, ISSUE, EXEC(cpu S1), EXEC(cpu S2, `done`=1). That is 5 cycles per instruction.
- The next `mem_rd` occurs in the cycle after `done`.
- `pc` changes on the edge that samples `done`. `cmp_flag` is sampled on that same edge.
- `d_inst` changes only on the WAIT edge. It must not change while the FSM is in S1 or S2.
- All outputs are registered or decoded from state only. There is no combinational path from `done` to `run` or `mem_rd`.

## Configuration
- `FETCH_BRANCH_EN` defined: branch resolution is enabled for instructions with `d_inst[1:0]`=2'b10.
  - Condition `d_inst[3:2]` selects the flag to match: 00 taken if `cmp_flag`=00, 01 taken if 01, 10 taken if 10, 11 never taken.
  - Taken: `pc` <= `d_inst[ADDR_W+3:4]`. Not taken: `pc`+1.
- `FETCH_BRANCH_EN` undefined: every instruction advances `pc`+1. `cmp_flag` is unused.

## Structure
- Shared package `fetch_pkg`:
  - state enum
  - `FMT_BRANCH`=2'b10
  - condition codes `COND_EQ`/`COND_GT`/`COND_LT`/`COND_NEVER`
  - `NOP_INST`=16'h0002
- One natural sub-module: `branch_eval`, combinational. Inputs `d_inst`, `cmp_flag`, `pc`; output `next_pc`. Compiled under `FETCH_BRANCH_EN`; trivial `pc`+1 otherwise.

## Test plan
- Reset, then idle 10 cycles: `pc`=0, `d_inst`=16'h0002, `run`/`mem_rd`/`busy`=0 throughout.
- Memory[0..2]=16'h2000,16'h4021,16'h6000; `start` with the FSM model attached:
  - `run` pulses in cycles 3, 8, 13.
  - `d_inst` matches each word.
  - `pc` reads 1, 2, 3 after each `done`.
- ADDR_W=4, `pc`=15: after `done`, `pc`=0 and the next `mem_addr`=0.
- `FETCH_BRANCH_EN`, memory[5]=16'h0302, branch to 0x30, COND_EQ:
  - `cmp_flag`=00 gives `pc`=0x30.
  - Repeat with `cmp_flag`=01: `pc`=6.
  - Without the macro: `pc`=6 in both cases.
- Pulse `stop` during EXEC: the current instruction completes, `pc` advances, then IDLE with `busy`=0 and no further `mem_rd`.
- Assert `reset` in EXEC: the next cycle shows IDLE, `pc`=0, `d_inst`=16'h0002. A later `done` is ignored.
